// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The slave modport is the loader; the master side is the stream source / memory.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_write_enable;
  logic [15:0] imem_write_address;
  logic [15:0] imem_write_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output imem_write_enable,
    output imem_write_address,
    output imem_write_data,
    output cpu_hold,
    output load_done,
    output load_error
  );

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  imem_write_enable,
    input  imem_write_address,
    input  imem_write_data,
    input  cpu_hold,
    input  load_done,
    input  load_error
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: parses A5 / length / big-endian payload / XOR frames and writes words
// into instruction memory, holding the CPU in reset until a frame checks out.
module imem_loader #(
  parameter int unsigned DEPTH          = 256,
  parameter logic [15:0] START_ADDRESS  = 16'h0000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic          clk,
  input logic          reset,
  imem_loader_if.slave bus
);

  localparam int unsigned   TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);
  localparam bit            TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [8:0]    DEPTH_W  = 9'(DEPTH);
  localparam logic [7:0]    HEADER   = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StLength,
    StDataHi,
    StDataLo,
    StCheck,
    StDone,
    StError
  } state_e;

  state_e        state_q;
  logic [7:0]    len_q;
  logic [8:0]    idx_q;
  logic [7:0]    hi_q;
  logic [7:0]    csum_q;
  logic [TW-1:0] tmo_q;
  logic          we_q;
  logic [15:0]   addr_q;
  logic [15:0]   data_q;
  logic          hold_q;
  logic          done_q;
  logic          err_q;

  logic       accept;
  logic       in_frame;
  logic [8:0] idx_inc;

  assign bus.byte_ready = ~reset;
  assign accept         = bus.byte_valid & ~reset;
  assign idx_inc        = idx_q + 9'd1;
  assign in_frame       = (state_q == StLength) || (state_q == StDataHi) ||
                          (state_q == StDataLo) || (state_q == StCheck);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      idx_q   <= '0;
      hi_q    <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (accept) begin
        tmo_q <= '0;
        unique case (state_q)
          StIdle, StDone, StError: begin
            // Non-header bytes outside a frame are dropped silently.
            if (bus.byte_data == HEADER) begin
              state_q <= StLength;
              hold_q  <= 1'b1;
              done_q  <= 1'b0;
              err_q   <= 1'b0;
              idx_q   <= '0;
              csum_q  <= '0;
            end
          end
          StLength: begin
            if (bus.byte_data == 8'd0 || {1'b0, bus.byte_data} > DEPTH_W) begin
              state_q <= StError;
              err_q   <= 1'b1;
            end else begin
              len_q   <= bus.byte_data;
              state_q <= StDataHi;
            end
          end
          StDataHi: begin
            hi_q    <= bus.byte_data;
            csum_q  <= csum_q ^ bus.byte_data;
            state_q <= StDataLo;
          end
          StDataLo: begin
            csum_q  <= csum_q ^ bus.byte_data;
            we_q    <= 1'b1;
            addr_q  <= START_ADDRESS + {7'd0, idx_q};
            data_q  <= {hi_q, bus.byte_data};
            idx_q   <= idx_inc;
            state_q <= (idx_inc == {1'b0, len_q}) ? StCheck : StDataHi;
          end
          StCheck: begin
            if (bus.byte_data == csum_q) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= StError;
              err_q   <= 1'b1;
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end else if (in_frame && TMO_EN) begin
        // Fires on the TIMEOUT_CYCLES-th consecutive idle edge inside a frame.
        if (tmo_q == TMO_LAST) begin
          state_q <= StError;
          err_q   <= 1'b1;
          tmo_q   <= '0;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end
    end
  end

  assign bus.imem_write_enable  = we_q;
  assign bus.imem_write_address = addr_q;
  assign bus.imem_write_data    = data_q;
  assign bus.cpu_hold           = hold_q;
  assign bus.load_done          = done_q;
  assign bus.load_error         = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames checked
// against a frame-position model (which byte completes which word, XOR of the payload).
`timescale 1ns/1ps
module tb_imem_loader;

  localparam logic [15:0] START = 16'hFFFE;  // exercises address wrap past 16'hFFFF
  localparam int          DEPTH = 4;
  localparam int          TMO   = 8;
  localparam logic [36:0] RST_VEC = {2'b00, 32'h0, 3'b100};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_loader_if bus ();

  imem_loader #(
    .DEPTH         (DEPTH),
    .START_ADDRESS (START),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad = 0;
  int strobes = 0;
  logic [7:0] frame[$];

  always @(negedge clk) if (bus.imem_write_enable === 1'b1) strobes++;

  // Present a byte, return at the negedge after the edge that accepted it.
  task automatic put(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'($urandom);
    repeat (n) @(negedge clk);
  endtask

  task automatic build_frame(input int n, input bit corrupt);
    logic [7:0] x;
    logic [7:0] b;
    frame.delete();
    frame.push_back(8'hA5);
    frame.push_back(8'(n));
    if (n != 0 && n <= DEPTH) begin
      x = 8'h00;
      for (int j = 0; j < 2 * n; j++) begin
        b = 8'($urandom);
        x ^= b;
        frame.push_back(b);
      end
      frame.push_back(corrupt ? (x ^ 8'($urandom_range(255, 1))) : x);
    end
  endtask

  task automatic send_frame(input int max_gap, input string tag);
    int n;
    bit good;
    logic [7:0] x;
    int s0;
    int last;
    #1;
    s0   = strobes;
    n    = int'(frame[1]);
    good = (n != 0) && (n <= DEPTH);
    x    = 8'h00;
    if (good) for (int j = 2; j < 2 + 2 * n; j++) x ^= frame[j];
    last = frame.size() - 1;
    for (int i = 0; i <= last; i++) begin
      logic       exp_we;
      logic [2:0] exp_f;
      logic [31:0] exp_wr;
      put(frame[i]);
      exp_we = good && i >= 3 && i <= 2 * n + 1 && (i % 2 == 1);
      total++;
      if (bus.imem_write_enable !== exp_we) begin
        bad++;
        $display("FAIL %s strobe byte %0d: got %b want %b", tag, i, bus.imem_write_enable, exp_we);
      end
      if (exp_we) begin
        exp_wr = {START + 16'((i - 3) / 2), frame[i - 1], frame[i]};
        total++;
        if ({bus.imem_write_address, bus.imem_write_data} !== exp_wr) begin
          bad++;
          $display("FAIL %s write byte %0d: got %h/%h want %h/%h", tag, i,
                   bus.imem_write_address, bus.imem_write_data, exp_wr[31:16], exp_wr[15:0]);
        end
      end
      exp_f = 3'b100;  // {cpu_hold, load_done, load_error}
      if (i == 1 && !good) exp_f = 3'b101;
      else if (good && i == 2 * n + 2) exp_f = (frame[i] == x) ? 3'b010 : 3'b101;
      total++;
      if ({bus.cpu_hold, bus.load_done, bus.load_error} !== exp_f) begin
        bad++;
        $display("FAIL %s flags byte %0d: got %b want %b", tag, i,
                 {bus.cpu_hold, bus.load_done, bus.load_error}, exp_f);
      end
      if (i < last && max_gap > 0) idle($urandom_range(max_gap, 0));
    end
    idle(1);
    #1;
    total++;
    if (strobes - s0 !== (good ? n : 0)) begin
      bad++;
      $display("FAIL %s strobe count: got %0d want %0d", tag, strobes - s0, good ? n : 0);
    end
  endtask

  task automatic test_reset;
    reset          = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.byte_ready, bus.imem_write_enable, bus.imem_write_address, bus.imem_write_data,
         bus.cpu_hold, bus.load_done, bus.load_error} !== RST_VEC) begin
      bad++;
      $display("FAIL reset values: got %h want %h", {bus.byte_ready, bus.imem_write_enable,
               bus.imem_write_address, bus.imem_write_data, bus.cpu_hold, bus.load_done,
               bus.load_error}, RST_VEC);
    end
    reset = 1'b0;
    #1;
    total++;
    if (bus.byte_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready after reset: got %b want 1", bus.byte_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_clean;
    frame = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_frame(0, "clean");
  endtask

  task automatic test_bad_checksum;
    frame = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    send_frame(0, "bad_cks");
  endtask

  task automatic test_length;
    frame = '{8'hA5, 8'h00};
    send_frame(0, "len_zero");
    frame = '{8'hA5, 8'h05};
    send_frame(0, "len_over");
    frame = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
    send_frame(0, "len_max");
  endtask

  task automatic test_timeout;
    int s0;
    #1;
    s0 = strobes;
    put(8'hA5);
    put(8'h01);
    put(8'h12);
    bus.byte_valid = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      total++;
      if (bus.load_error !== (k == TMO)) begin
        bad++;
        $display("FAIL timeout edge %0d: got %b want %b", k, bus.load_error, (k == TMO));
      end
    end
    #1;
    total++;
    if ({bus.cpu_hold, bus.load_done, strobes - s0} !== {2'b10, 32'd0}) begin
      bad++;
      $display("FAIL timeout aftermath: got hold=%b done=%b strobes=%0d want 1/0/0",
               bus.cpu_hold, bus.load_done, strobes - s0);
    end
  endtask

  task automatic test_noise_reload;
    int s0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    s0 = strobes;
    put(8'h00);
    put(8'hFF);
    put(8'h5A);
    idle(1);
    #1;
    total++;
    if ({bus.cpu_hold, bus.load_done, bus.load_error, strobes - s0} !== {3'b100, 32'd0}) begin
      bad++;
      $display("FAIL noise in idle: got flags %b strobes %0d want 100/0",
               {bus.cpu_hold, bus.load_done, bus.load_error}, strobes - s0);
    end
    frame = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_frame(1, "pre_reload");
    put(8'h3C);
    total++;
    if ({bus.cpu_hold, bus.load_done, bus.load_error} !== 3'b010) begin
      bad++;
      $display("FAIL noise in done: got %b want 010", {bus.cpu_hold, bus.load_done, bus.load_error});
    end
    frame = '{8'hA5, 8'h01, 8'hBE, 8'hEF, 8'h51};
    send_frame(0, "reload");
  endtask

  task automatic test_reset_mid;
    int s0;
    put(8'hA5);
    put(8'h02);
    put(8'h12);
    reset = 1'b1;
    #1;
    total++;
    if ({bus.byte_ready, bus.imem_write_enable, bus.imem_write_address, bus.imem_write_data,
         bus.cpu_hold, bus.load_done, bus.load_error} !== RST_VEC) begin
      bad++;
      $display("FAIL mid reset values: got %h want %h", {bus.byte_ready, bus.imem_write_enable,
               bus.imem_write_address, bus.imem_write_data, bus.cpu_hold, bus.load_done,
               bus.load_error}, RST_VEC);
    end
    s0 = strobes;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h34;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({bus.byte_ready, strobes - s0} !== {1'b0, 32'd0}) begin
      bad++;
      $display("FAIL during reset: got ready=%b strobes=%0d want 0/0", bus.byte_ready,
               strobes - s0);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.byte_valid = 1'b0;
    frame = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_frame(0, "after_reset");
  endtask

  task automatic test_random;
    for (int f = 0; f < 30; f++) begin
      build_frame($urandom_range(6, 0), ($urandom_range(3, 0) == 0));
      send_frame(3, "random");
      idle($urandom_range(4, 0));
    end
  endtask

  task automatic test_back_to_back;
    for (int f = 0; f < 6; f++) begin
      build_frame($urandom_range(DEPTH, 1), 1'b0);
      send_frame(0, "b2b");
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    test_reset();
    test_clean();
    test_bad_checksum();
    test_length();
    test_timeout();
    test_noise_reload();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
